// File: rtl/corelet_pkg.sv
// corelet_pkg: constants and types shared by the partial-sum accumulator.
//   default_col / default_psum_bw / default_n_rows : default geometry of a pass
//   addr_w                                         : PMEM address width
//   state_t                                        : accumulator sequencing states
package corelet_pkg;

  localparam int default_col     = 8;
  localparam int default_psum_bw = 16;
  localparam int default_n_rows  = 36;
  localparam int addr_w          = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    READ   = 3'd2,
    ADD    = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/sat_add_lane.sv
// sat_add_lane: one two's-complement lane, y = relu ? max(0, sat(a+b)) : sat(a+b).
//   a, b : lane operands (psum_bw bits, signed)
//   relu : clamp negative results to zero
//   y    : saturated (and optionally rectified) result
module sat_add_lane #(
  parameter int psum_bw = 16
) (
  input  logic [psum_bw-1:0] a,
  input  logic [psum_bw-1:0] b,
  input  logic               relu,
  output logic [psum_bw-1:0] y
);

  localparam logic [psum_bw-1:0] max_v = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] min_v = {1'b1, {(psum_bw-1){1'b0}}};

  logic [psum_bw:0]   wide;
  logic [psum_bw-1:0] sat;

  // Sign-extended add; overflow shows up as the two top bits disagreeing.
  always_comb begin
    wide = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (wide[psum_bw] != wide[psum_bw-1]) begin
      sat = wide[psum_bw] ? min_v : max_v;
    end else begin
      sat = wide[psum_bw-1:0];
    end
    if (relu && sat[psum_bw-1]) begin
      y = '0;
    end else begin
      y = sat;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: pops n_rows rows from the OFIFO and writes them to PMEM,
// either overwriting (first pass) or read-add-writing with saturation, with an
// optional ReLU on the final pass.
//   clk, reset                   : clock, synchronous active-high reset
//   start, first_pass, last_pass,
//   base_addr                    : pass command, sampled in IDLE
//   in_valid, in_data, in_ready  : OFIFO row handshake
//   OP_q, OP_d, OP_addr,
//   OP_cen, OP_wen               : PMEM SRAM port (enables active low, 1-cycle read latency)
//   busy, done                   : status (done is a one-cycle pulse)
module psum_accumulator
  import corelet_pkg::*;
#(
  parameter int col     = default_col,
  parameter int psum_bw = default_psum_bw,
  parameter int n_rows  = default_n_rows
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     first_pass,
  input  logic                     last_pass,
  input  logic [addr_w-1:0]        base_addr,
  input  logic                     in_valid,
  input  logic [col*psum_bw-1:0]   in_data,
  output logic                     in_ready,
  input  logic [col*psum_bw-1:0]   OP_q,
  output logic [col*psum_bw-1:0]   OP_d,
  output logic [addr_w-1:0]        OP_addr,
  output logic                     OP_cen,
  output logic                     OP_wen,
  output logic                     busy,
  output logic                     done
);

  state_t                   state;
  state_t                   next_state;
  logic [addr_w-1:0]        row;
  logic [addr_w-1:0]        base;
  logic [addr_w-1:0]        row_addr;
  logic                     first_r;
  logic                     last_r;
  logic [col*psum_bw-1:0]   hold;
  logic [col*psum_bw-1:0]   sum;
  logic [col*psum_bw-1:0]   lane_out;

  // Address arithmetic is truncated to addr_w, so base+row wraps past the top of PMEM.
  assign row_addr = base + row;

  // Shared lane array: in ADD it forms sat(hold + OP_q); on a first pass the
  // PMEM operand is forced to zero so the same lanes just rectify the hold row.
  for (genvar i = 0; i < col; i++) begin : g_lane
    sat_add_lane #(.psum_bw(psum_bw)) u_lane (
      .a    (hold[i*psum_bw +: psum_bw]),
      .b    (first_r ? {psum_bw{1'b0}} : OP_q[i*psum_bw +: psum_bw]),
      .relu (last_r),
      .y    (lane_out[i*psum_bw +: psum_bw])
    );
  end

  // Next-state logic for the pass sequencer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? ACCEPT : IDLE;
      ACCEPT:  begin
        if (in_valid) begin
          next_state = first_r ? WRITE : READ;
        end else begin
          next_state = ACCEPT;
        end
      end
      READ:    next_state = ADD;
      ADD:     next_state = WRITE;
      WRITE:   next_state = (row == addr_w'(n_rows - 1)) ? DONE : ACCEPT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, row counter, latched command and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      row     <= '0;
      base    <= '0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
      hold    <= '0;
      sum     <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (start) begin
            first_r <= first_pass;
            last_r  <= last_pass;
            base    <= base_addr;
            row     <= '0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            hold <= in_data;
          end
        end
        ADD:     sum <= lane_out;
        WRITE:   row <= row + addr_w'(1);
        default: ;
      endcase
    end
  end

  // Output decode from registered state/data only; nothing here sees in_data.
  always_comb begin
    in_ready = 1'b0;
    busy     = (state != IDLE);
    done     = 1'b0;
    OP_cen   = 1'b1;
    OP_wen   = 1'b1;
    OP_addr  = '0;
    OP_d     = '0;
    case (state)
      ACCEPT: in_ready = 1'b1;
      READ: begin
        OP_cen  = 1'b0;
        OP_addr = row_addr;
      end
      WRITE: begin
        OP_cen  = 1'b0;
        OP_wen  = 1'b0;
        OP_addr = row_addr;
        OP_d    = first_r ? lane_out : sum;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: drives whole passes into psum_accumulator against a
// behavioural PMEM model and an arithmetic reference of the expected contents.
module tb_psum_accumulator;

  localparam int NR  = 36;
  localparam int COL = 8;
  localparam int W   = 128;

  logic         clk = 1'b0;
  logic         reset, start, first_pass, last_pass, in_valid;
  logic [8:0]   base_addr;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [W-1:0] OP_q, OP_d;
  logic [8:0]   OP_addr;
  logic         OP_cen, OP_wen, busy, done;

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk(clk), .reset(reset), .start(start), .first_pass(first_pass),
    .last_pass(last_pass), .base_addr(base_addr), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .OP_q(OP_q), .OP_d(OP_d),
    .OP_addr(OP_addr), .OP_cen(OP_cen), .OP_wen(OP_wen), .busy(busy), .done(done)
  );

  logic [W-1:0] mem     [512];
  logic [W-1:0] exp_mem [512];
  logic [W-1:0] rows    [NR];

  int vectors = 0, miscompares = 0;
  int nreads = 0, nwrites = 0, rbw_bad = 0, last_rd = -1;
  bit check_rbw = 1'b0;

  logic         tb_we = 1'b0;
  logic [8:0]   tb_addr = 9'd0;
  logic [W-1:0] tb_data = '0;

  // PMEM model: 1-cycle read latency, plus a bench-side preload port.
  always @(posedge clk) begin
    if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end else if (!OP_cen) begin
      if (!OP_wen) begin
        mem[OP_addr] <= OP_d;
        nwrites <= nwrites + 1;
        if (check_rbw && last_rd != int'(OP_addr)) rbw_bad <= rbw_bad + 1;
      end else begin
        OP_q    <= mem[OP_addr];
        nreads  <= nreads + 1;
        last_rd <= int'(OP_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    for (int a = 0; a < 512; a++) begin
      vectors++;
      if (mem[a] !== exp_mem[a]) begin
        miscompares++;
        $display("FAIL %s mem[%0d]: got %h, want %h", tag, a, mem[a], exp_mem[a]);
      end
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: what PMEM must hold after nr rows of a pass.
  task automatic apply_model(input bit fp, input bit lp, input int base, input int nr);
    for (int r = 0; r < nr; r++) begin
      int a;
      logic [W-1:0] w;
      a = (base + r) % 512;
      w = exp_mem[a];
      for (int l = 0; l < COL; l++) begin
        int x, o, v;
        logic [15:0] xs, os;
        xs = rows[r][16*l +: 16];
        os = w[16*l +: 16];
        x = int'($signed(xs));
        o = int'($signed(os));
        v = fp ? x : sat16(o + x);
        if (lp && v < 0) v = 0;
        w[16*l +: 16] = v[15:0];
      end
      exp_mem[a] = w;
    end
  endtask

  task automatic poke(input int a, input logic [W-1:0] d);
    tb_we = 1'b1;
    tb_addr = a[8:0];
    tb_data = d;
    exp_mem[a] = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  function automatic logic [13:0] outs();
    return {in_ready, busy, done, OP_cen, OP_wen, OP_addr};
  endfunction

  task automatic rand_rows();
    for (int r = 0; r < NR; r++) rows[r] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Runs one pass. stall_row>=0 drops in_valid 5 cycles before that row;
  // abort_row>=0 asserts reset while that row is in its READ cycle.
  task automatic run_pass(input string tag, input bit fp, input bit lp, input logic [8:0] base,
                          input int stall_row, input int abort_row, input int exp_cyc);
    int r = 0, cyc = 0, stall = 0, rd0, wr0, rbw0, wr_hold;
    bit fin = 1'b0, xfer, stalled = 1'b0;
    rd0 = nreads; wr0 = nwrites; rbw0 = rbw_bad;
    check_rbw = !fp;
    @(negedge clk);
    start = 1'b1; first_pass = fp; last_pass = lp; base_addr = base;
    @(negedge clk);
    start = 1'b0; first_pass = !fp; last_pass = !lp; base_addr = ~base;
    while (!fin && cyc < 2000) begin
      if (stalled) chk({tag, " stall_hold"}, {in_ready, OP_cen}, 2'b11);
      stalled = 1'b0;
      if (done) begin
        fin = 1'b1;
      end else begin
        if (abort_row >= 0 && r == abort_row + 1 && !OP_cen && OP_wen) begin
          reset = 1'b1; in_valid = 1'b0;
          @(negedge clk);
          chk({tag, " abort_outs"}, outs(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0});
          chk({tag, " abort_d"}, OP_d, '0);
          reset = 1'b0;
          wr_hold = nwrites;
          repeat (5) begin
            @(negedge clk);
            chk({tag, " post_abort_idle"}, {busy, OP_cen}, 2'b01);
          end
          chk({tag, " post_abort_writes"}, nwrites, wr_hold);
          return;
        end
        if (in_ready && r == stall_row && stall < 5) begin
          in_valid = 1'b0; stall++; stalled = 1'b1;
        end else begin
          in_valid = (r < NR);
          in_data = rows[(r < NR) ? r : 0];
        end
        xfer = in_valid && in_ready;
        @(posedge clk);
        if (xfer) r++;
        cyc++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    if (!fin) $display("FAIL %s timeout: no done within %0d cycles", tag, cyc);
    chk({tag, " cycles"}, cyc, exp_cyc);
    chk({tag, " busy_at_done"}, busy, 1'b1);
    @(negedge clk);
    chk({tag, " done_pulse"}, {done, busy}, 2'b00);
    chk({tag, " writes"}, nwrites - wr0, NR);
    chk({tag, " reads"}, nreads - rd0, fp ? 0 : NR);
    chk({tag, " read_before_write"}, rbw_bad - rbw0, 0);
  endtask

  typedef struct {
    int pm;
    int inp;
    bit lp;
    int exp;
  } sat_vec_t;

  initial begin
    sat_vec_t tbl[6];
    logic [W-1:0] ev;
    logic [15:0] e16, p16, i16;
    int b;
    bit fp, lp;

    tbl[0] = '{30000, 5000, 1'b0, 32767};
    tbl[1] = '{-30000, -5000, 1'b0, -32768};
    tbl[2] = '{3, -10, 1'b1, 0};
    tbl[3] = '{3, 4, 1'b1, 7};
    tbl[4] = '{-100, 50, 1'b0, -50};
    tbl[5] = '{32767, 1, 1'b1, 32767};

    reset = 1'b1; start = 1'b0; first_pass = 1'b0; last_pass = 1'b0;
    base_addr = 9'd0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0});
    chk("reset_d", OP_d, '0);
    start = 1'b1;
    @(negedge clk);
    chk("start_in_reset", outs(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0});
    start = 1'b0;
    reset = 1'b0;
    for (int a = 0; a < 512; a++) poke(a, '0);

    // Overwrite pass, rows carry their index.
    for (int r = 0; r < NR; r++) rows[r] = {COL{16'(r)}};
    run_pass("first", 1'b1, 1'b0, 9'd0, -1, -1, 72);
    apply_model(1'b1, 1'b0, 0, NR);
    chk_mem("first");
    ev = {COL{16'd5}};
    chk("first_row5", mem[5], ev);

    // Accumulate the same rows: lanes become 2r.
    run_pass("second", 1'b0, 1'b0, 9'd0, -1, -1, 144);
    apply_model(1'b0, 1'b0, 0, NR);
    chk_mem("second");
    ev = {COL{16'd14}};
    chk("second_row7", mem[7], ev);

    // Saturation / ReLU table, checked on lane 0 of row 0.
    for (int i = 0; i < 6; i++) begin
      b = $urandom_range(0, 511);
      p16 = tbl[i].pm[15:0];
      i16 = tbl[i].inp[15:0];
      e16 = tbl[i].exp[15:0];
      for (int r = 0; r < NR; r++) begin
        ev = {$urandom, $urandom, $urandom, $urandom};
        ev[15:0] = p16;
        poke((b + r) % 512, ev);
        rows[r] = {$urandom, $urandom, $urandom, $urandom};
        rows[r][15:0] = i16;
      end
      run_pass($sformatf("sat%0d", i), 1'b0, tbl[i].lp, b[8:0], -1, -1, 144);
      apply_model(1'b0, tbl[i].lp, b, NR);
      chk($sformatf("sat%0d_lane0", i), mem[b][15:0], e16);
      chk_mem($sformatf("sat%0d", i));
    end

    // Address wrap from 500.
    rand_rows();
    run_pass("wrap", 1'b0, 1'b0, 9'd500, -1, -1, 144);
    apply_model(1'b0, 1'b0, 500, NR);
    chk_mem("wrap");

    // Five-cycle in_valid stall before row 10.
    rand_rows();
    run_pass("stall", 1'b0, 1'b0, 9'd100, 10, -1, 149);
    apply_model(1'b0, 1'b0, 100, NR);
    chk_mem("stall");

    // Random passes.
    for (int k = 0; k < 4; k++) begin
      rand_rows();
      fp = $urandom_range(0, 1);
      lp = $urandom_range(0, 1);
      b = $urandom_range(0, 511);
      run_pass($sformatf("rand%0d", k), fp, lp, b[8:0], -1, -1, fp ? 72 : 144);
      apply_model(fp, lp, b, NR);
      chk_mem($sformatf("rand%0d", k));
    end

    // Reset during the READ of row 3: only rows 0-2 land in PMEM.
    rand_rows();
    run_pass("abort", 1'b0, 1'b0, 9'd200, -1, 3, 0);
    apply_model(1'b0, 1'b0, 200, 3);
    chk_mem("abort");

    // The block is usable again after the abort.
    rand_rows();
    run_pass("after_abort", 1'b1, 1'b1, 9'd300, -1, -1, 72);
    apply_model(1'b1, 1'b1, 300, NR);
    chk_mem("after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
